// File: rtl/hamming_pkg.sv
// Shared constants and types for the (7,4) Hamming receive path.
package hamming_pkg;

  localparam int unsigned CODE_W = 7;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned SYN_W  = 3;

  // Codeword positions (1-based, a1..a7) that carry data bits d1..d4.
  localparam int unsigned DATA_POS_1 = 3;
  localparam int unsigned DATA_POS_2 = 5;
  localparam int unsigned DATA_POS_3 = 6;
  localparam int unsigned DATA_POS_4 = 7;

  typedef enum logic [1:0] {
    COLLECT,
    CORRECT,
    PRESENT
  } state_e;

endpackage

// File: rtl/hamming74_fix.sv
// Combinational (7,4) Hamming syndrome and single-error correction.
// Codeword bit [0] holds a1 and bit [6] holds a7.
module hamming74_fix
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic [SYN_W-1:0]  o_syndrome,
  output logic [DATA_W-1:0] o_data
);

  logic [SYN_W-1:0]  w_syn;
  logic [CODE_W-1:0] w_fixed;

  // Syndrome bits are the parity checks over positions with index bit k set.
  always_comb begin
    w_syn[0] = i_code[0] ^ i_code[2] ^ i_code[4] ^ i_code[6];
    w_syn[1] = i_code[1] ^ i_code[2] ^ i_code[5] ^ i_code[6];
    w_syn[2] = i_code[3] ^ i_code[4] ^ i_code[5] ^ i_code[6];
  end

  // A nonzero syndrome names the 1-based position to invert, parity bits included.
  always_comb begin
    w_fixed = i_code;
    for (int unsigned i = 0; i < CODE_W; i++) begin
      if (w_syn == SYN_W'(i + 1)) begin
        w_fixed[i] = ~i_code[i];
      end
    end
  end

  assign o_syndrome = w_syn;
  assign o_data     = {w_fixed[DATA_POS_4-1], w_fixed[DATA_POS_3-1],
                       w_fixed[DATA_POS_2-1], w_fixed[DATA_POS_1-1]};

endmodule

// File: rtl/hamming_rx_ctrl.sv
// Serial (7,4) Hamming receiver: collects a codeword bit by bit, corrects it in
// one cycle and presents the data word on a valid/ready output.
module hamming_rx_ctrl
  import hamming_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_bit_in,
  input  logic              i_bit_valid,
  output logic              o_bit_ready,
  output logic [DATA_W-1:0] o_data_out,
  output logic [SYN_W-1:0]  o_syndrome_out,
  output logic              o_err_flag,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  input  logic              i_cnt_clr,
  output logic [CNT_W-1:0]  o_err_count
);

  state_e              r_state;
  logic [2:0]          r_idx;
  logic [CODE_W-1:0]   r_shift;
  logic [DATA_W-1:0]   r_data;
  logic [SYN_W-1:0]    r_syn;
  logic                r_err;
  logic                r_out_valid;
  logic                r_bit_ready;
  logic [CNT_W-1:0]    r_err_count;

  logic [SYN_W-1:0]    w_syn;
  logic [DATA_W-1:0]   w_data;
  logic                w_accept;

  assign w_accept = i_bit_valid & r_bit_ready;

  hamming74_fix u_fix (
    .i_code     (r_shift),
    .o_syndrome (w_syn),
    .o_data     (w_data)
  );

  // Sequencer: shift in a word, latch the corrected result, hold it until taken.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= COLLECT;
      r_idx       <= 3'd1;
      r_shift     <= '0;
      r_data      <= '0;
      r_syn       <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_bit_ready <= 1'b1;
    end else begin
      unique case (r_state)
        COLLECT: begin
          if (w_accept) begin
            r_shift[r_idx - 3'd1] <= i_bit_in;
            if (r_idx == 3'd7) begin
              r_idx       <= 3'd1;
              r_bit_ready <= 1'b0;
              r_state     <= CORRECT;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        CORRECT: begin
          r_data      <= w_data;
          r_syn       <= w_syn;
          r_err       <= (w_syn != '0);
          r_out_valid <= 1'b1;
          r_state     <= PRESENT;
        end
        PRESENT: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_bit_ready <= 1'b1;
            r_state     <= COLLECT;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_bit_ready <= 1'b1;
          r_state     <= COLLECT;
        end
      endcase
    end
  end

  // Saturating corrected-word counter; a clear beats a same-cycle increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_count <= '0;
    end else if (i_cnt_clr) begin
      r_err_count <= '0;
    end else if ((r_state == CORRECT) && (w_syn != '0) && (r_err_count != '1)) begin
      r_err_count <= r_err_count + CNT_W'(1);
    end
  end

  assign o_bit_ready    = r_bit_ready;
  assign o_data_out     = r_data;
  assign o_syndrome_out = r_syn;
  assign o_err_flag     = r_err;
  assign o_out_valid    = r_out_valid;
  assign o_err_count    = r_err_count;

endmodule

// File: tb/tb_hamming_rx_ctrl.sv
// Bench for hamming_rx_ctrl: directed scenarios plus randomized words, checked
// against an index-XOR Hamming model. A second instance with a 2-bit counter
// runs in lockstep to exercise counter saturation.
module tb_hamming_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit_in;
  logic       bit_valid;
  logic       out_ready;
  logic       cnt_clr;

  logic       a_bit_ready, a_err, a_out_valid;
  logic [3:0] a_data;
  logic [2:0] a_syn;
  logic [7:0] a_cnt;

  logic       b_bit_ready, b_err, b_out_valid;
  logic [3:0] b_data;
  logic [2:0] b_syn;
  logic [1:0] b_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp8   = 0;
  int exp2   = 0;

  always #5 clk = ~clk;

  hamming_rx_ctrl #(.CNT_W(8)) dut_a (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_bit_in       (bit_in),
    .i_bit_valid    (bit_valid),
    .o_bit_ready    (a_bit_ready),
    .o_data_out     (a_data),
    .o_syndrome_out (a_syn),
    .o_err_flag     (a_err),
    .o_out_valid    (a_out_valid),
    .i_out_ready    (out_ready),
    .i_cnt_clr      (cnt_clr),
    .o_err_count    (a_cnt)
  );

  hamming_rx_ctrl #(.CNT_W(2)) dut_b (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_bit_in       (bit_in),
    .i_bit_valid    (bit_valid),
    .o_bit_ready    (b_bit_ready),
    .o_data_out     (b_data),
    .o_syndrome_out (b_syn),
    .o_err_flag     (b_err),
    .o_out_valid    (b_out_valid),
    .i_out_ready    (out_ready),
    .i_cnt_clr      (cnt_clr),
    .o_err_count    (b_cnt)
  );

  // Model: syndrome is the XOR of the indices of all set bits.
  function automatic logic [2:0] model_syn(input logic [7:1] a);
    logic [2:0] s = 3'd0;
    for (int i = 1; i <= 7; i++) if (a[i]) s = s ^ 3'(i);
    return s;
  endfunction

  function automatic logic [3:0] model_data(input logic [7:1] a);
    logic [7:1] f = a;
    logic [2:0] s = model_syn(a);
    if (s != 3'd0) f[s] = ~f[s];
    return {f[7], f[6], f[5], f[3]};
  endfunction

  function automatic logic [7:1] model_encode(input logic [3:0] d);
    logic [7:1] a = '0;
    logic [2:0] s;
    a[3] = d[0]; a[5] = d[1]; a[6] = d[2]; a[7] = d[3];
    s = model_syn(a);
    a[1] = s[0]; a[2] = s[1]; a[4] = s[2];
    return a;
  endfunction

  // Drive a[1]..a[7]; mode 0 contiguous, 1 alternating bubbles, 2 random bubbles.
  task automatic send_bits(input logic [7:1] a, input int nbits, input int mode);
    for (int i = 1; i <= nbits; i++) begin
      if ((mode == 1 && i > 1) || (mode == 2 && $urandom_range(0, 1) == 1)) begin
        bit_valid = 1'b0;
        bit_in    = 1'($urandom);
        @(posedge clk); #1;
      end
      bit_valid = 1'b1;
      bit_in    = a[i];
      @(posedge clk); #1;
    end
    bit_valid = 1'b0;
  endtask

  // Called in the CORRECT cycle; checks result, stalls, then completes handshake.
  task automatic expect_word(input logic [7:1] a, input int stall, input bit clr,
                             input string name);
    logic [2:0] es;
    logic [3:0] ed;
    logic       ee;
    logic [3:0] hold_d;
    logic [2:0] hold_s;
    logic       hold_e;
    int         waited;
    es = model_syn(a);
    ed = model_data(a);
    ee = (es != 3'd0);
    if (clr) begin
      exp8 = 0; exp2 = 0;
    end else if (ee) begin
      if (exp8 < 255) exp8++;
      if (exp2 < 3) exp2++;
    end
    n_cmp++;
    if (a_out_valid !== 1'b0 || a_bit_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s correct_phase: valid/ready %b%b want 00", name, a_out_valid,
               a_bit_ready);
    end
    out_ready = (stall == 0);
    cnt_clr   = clr;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    n_cmp++;
    if (a_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s latency: out_valid %b want 1", name, a_out_valid);
      waited = 0;
      while (a_out_valid !== 1'b1 && waited < 10) begin
        @(posedge clk); #1; waited++;
      end
    end
    n_cmp++;
    if (a_data !== ed || a_syn !== es || a_err !== ee || a_bit_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s result: got d=%h s=%0d e=%b r=%b want d=%h s=%0d e=%b r=0", name,
               a_data, a_syn, a_err, a_bit_ready, ed, es, ee);
    end
    n_cmp++;
    if (a_cnt !== 8'(exp8) || b_cnt !== 2'(exp2)) begin
      n_fail++;
      $display("FAIL %s err_count: got %0d/%0d want %0d/%0d", name, a_cnt, b_cnt, exp8,
               exp2);
    end
    n_cmp++;
    if (b_data !== ed || b_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s narrow_inst: got d=%h v=%b want d=%h v=1", name, b_data,
               b_out_valid, ed);
    end
    hold_d = a_data; hold_s = a_syn; hold_e = a_err;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (a_out_valid !== 1'b1 || a_bit_ready !== 1'b0 || a_data !== hold_d ||
          a_syn !== hold_s || a_err !== hold_e) begin
        n_fail++;
        $display("FAIL %s stall%0d: got v=%b r=%b d=%h s=%0d want v=1 r=0 d=%h s=%0d",
                 name, k, a_out_valid, a_bit_ready, a_data, a_syn, hold_d, hold_s);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    bit_valid = 1'b0;
    n_cmp++;
    if (a_out_valid !== 1'b0 || a_bit_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s after_handshake: valid/ready %b%b want 01", name, a_out_valid,
               a_bit_ready);
    end
  endtask

  task automatic check_reset_values(input string name);
    n_cmp++;
    if (a_out_valid !== 1'b0 || a_data !== 4'd0 || a_syn !== 3'd0 || a_err !== 1'b0 ||
        a_cnt !== 8'd0 || b_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL %s reset_vals: got v=%b d=%h s=%0d e=%b c=%0d/%0d want all 0", name,
               a_out_valid, a_data, a_syn, a_err, a_cnt, b_cnt);
    end
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    exp8 = 0; exp2 = 0;
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (a_bit_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: bit_ready %b want 1", a_bit_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (a_bit_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ready/valid %b%b want 10", a_bit_ready, a_out_valid);
    end
  endtask

  task automatic test_clean();
    send_bits(7'b1100110, 7, 0);
    expect_word(7'b1100110, 0, 1'b0, "clean");
  endtask

  task automatic test_data_err();
    send_bits(7'b1110110, 7, 0);
    expect_word(7'b1110110, 0, 1'b0, "data_err");
  endtask

  task automatic test_parity_backpressure();
    send_bits(7'b1100111, 7, 0);
    expect_word(7'b1100111, 5, 1'b0, "parity_bp");
  endtask

  // Bits offered while busy must be ignored, so the next word still decodes.
  task automatic test_bubbles();
    send_bits(7'b1100110, 7, 1);
    bit_valid = 1'b1; bit_in = 1'b1;
    expect_word(7'b1100110, 2, 1'b0, "bubbles_alt");
    send_bits(7'b1110110, 7, 2);
    bit_valid = 1'b1; bit_in = 1'b1;
    expect_word(7'b1110110, 0, 1'b0, "bubbles_rand");
  endtask

  task automatic test_sat_clear();
    logic [7:1] w;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    exp8 = 0; exp2 = 0;
    n_cmp++;
    if (a_cnt !== 8'd0 || b_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_clear: got %0d/%0d want 0/0", a_cnt, b_cnt);
    end
    for (int n = 0; n < 5; n++) begin
      w = model_encode(4'($urandom));
      w[$urandom_range(1, 7)] ^= 1'b1;
      send_bits(w, 7, 0);
      expect_word(w, 0, (n == 4), (n == 4) ? "sat_clear" : "sat");
    end
  endtask

  task automatic test_reset_midword();
    logic [7:1] w;
    send_bits(7'b1011010, 4, 0);
    pulse_reset();
    w = model_encode(4'b0110);
    w[6] ^= 1'b1;
    send_bits(w, 7, 0);
    expect_word(w, 0, 1'b0, "after_midword_rst");
    send_bits(7'b1110110, 7, 0);
    out_ready = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (a_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL present_before_rst: out_valid %b want 1", a_out_valid);
    end
    pulse_reset();
    send_bits(7'b1100110, 7, 0);
    expect_word(7'b1100110, 1, 1'b0, "after_present_rst");
  endtask

  task automatic test_random();
    logic [7:1] w;
    int         pos;
    for (int n = 0; n < 25; n++) begin
      w   = model_encode(4'($urandom));
      pos = $urandom_range(0, 7);
      if (pos != 0) w[pos] ^= 1'b1;
      send_bits(w, 7, $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        bit_valid = 1'b1; bit_in = 1'($urandom);
      end
      expect_word(w, $urandom_range(0, 3), 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_data_err();
    test_parity_backpressure();
    test_bubbles();
    test_sat_clear();
    test_reset_midword();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
